// File: rtl/avr_gpio_port_pkg.sv
// Shared definitions for the AVR GPIO port: per-port IO addresses,
// pin-count limit and register-select encoding.
package avr_gpio_port_pkg;

  localparam int P_WIDTH_MAX = 8;

  localparam logic [5:0] PINB_ADDR  = 6'h03;
  localparam logic [5:0] DDRB_ADDR  = 6'h04;
  localparam logic [5:0] PORTB_ADDR = 6'h05;
  localparam logic [5:0] PINC_ADDR  = 6'h06;
  localparam logic [5:0] DDRC_ADDR  = 6'h07;
  localparam logic [5:0] PORTC_ADDR = 6'h08;
  localparam logic [5:0] PIND_ADDR  = 6'h09;
  localparam logic [5:0] DDRD_ADDR  = 6'h0A;
  localparam logic [5:0] PORTD_ADDR = 6'h0B;
  localparam logic [5:0] PINE_ADDR  = 6'h0C;
  localparam logic [5:0] DDRE_ADDR  = 6'h0D;
  localparam logic [5:0] PORTE_ADDR = 6'h0E;
  localparam logic [5:0] PCMSK_DEF  = 6'h3F;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PIN,
    SEL_DDR,
    SEL_PORT,
    SEL_PCMSK
  } reg_sel_e;

endpackage

// File: rtl/avr_gpio_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs,
// asynchronous active-low reset.
module avr_gpio_sync2
  import avr_gpio_port_pkg::*;
#(
  parameter int P_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P_WIDTH-1:0] d,
  output logic [P_WIDTH-1:0] q
);

  logic [P_WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/avr_gpio_port.sv
// AVR-style GPIO port: PORTx/DDRx/PINx, overrides, input sync.
// Pin-change logic and PCMSKx exist only with AVR_GPIO_PCINT_EN.
module avr_gpio_port
  import avr_gpio_port_pkg::*;
#(
  parameter int         P_WIDTH    = 8,
  parameter logic [5:0] PINX_ADDR  = PINB_ADDR,
  parameter logic [5:0] DDRX_ADDR  = DDRB_ADDR,
  parameter logic [5:0] PORTX_ADDR = PORTB_ADDR,
  parameter logic [5:0] PCMSK_ADDR = PCMSK_DEF
) (
  input  logic               cp2,
  input  logic               ireset,
  input  logic [5:0]         IO_Addr,
  input  logic               iore,
  input  logic               iowe,
  input  logic [7:0]         dbus_in,
  output logic [7:0]         dbus_out,
  output logic               out_en,
  input  logic [P_WIDTH-1:0] pin_i,
  input  logic               PUD,
  input  logic               SLEEP,
  input  logic [P_WIDTH-1:0] puoe,
  input  logic [P_WIDTH-1:0] puov,
  input  logic [P_WIDTH-1:0] ddoe,
  input  logic [P_WIDTH-1:0] ddov,
  input  logic [P_WIDTH-1:0] pvoe,
  input  logic [P_WIDTH-1:0] pvov,
  input  logic [P_WIDTH-1:0] dieoe,
  input  logic [P_WIDTH-1:0] dieov,
  output logic [P_WIDTH-1:0] pu_n,
  output logic [P_WIDTH-1:0] dd,
  output logic [P_WIDTH-1:0] pv,
  output logic [P_WIDTH-1:0] die,
  output logic [P_WIDTH-1:0] pin_sync,
  input  logic               pcie,
  input  logic               pcif_clr,
  output logic               pcif,
  output logic               pcint_req
);

  logic [P_WIDTH-1:0] portx;
  logic [P_WIDTH-1:0] ddrx;
  logic [P_WIDTH-1:0] pcmsk_rd;
  logic [P_WIDTH-1:0] wd;
  logic [P_WIDTH-1:0] pu;
  logic [P_WIDTH-1:0] gated;
  logic [P_WIDTH-1:0] s2;
  logic [7:0]         rd;
  reg_sel_e           sel;

  assign wd = dbus_in[P_WIDTH-1:0];

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (IO_Addr == PINX_ADDR):  sel = SEL_PIN;
      (IO_Addr == DDRX_ADDR):  sel = SEL_DDR;
      (IO_Addr == PORTX_ADDR): sel = SEL_PORT;
`ifdef AVR_GPIO_PCINT_EN
      (IO_Addr == PCMSK_ADDR): sel = SEL_PCMSK;
`endif
      default:                 sel = SEL_NONE;
    endcase
  end

  assign pu   = (puoe & puov)
              | (~puoe & portx & ~ddrx & {P_WIDTH{~PUD}});
  assign pu_n = ~pu;
  assign dd   = (ddoe & ddov) | (~ddoe & ddrx);
  assign pv   = (pvoe & pvov) | (~pvoe & portx);
  assign die  = (dieoe & ~dieov) | (~dieoe & {P_WIDTH{SLEEP}});

  assign gated = pin_i & ~die;

  avr_gpio_sync2 #(
    .P_WIDTH(P_WIDTH)
  ) u_sync (
    .clk  (cp2),
    .rst_n(ireset),
    .d    (gated),
    .q    (s2)
  );

  assign pin_sync = s2;

  // PINx write toggles PORTx bits where a 1 is written
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      portx <= '0;
      ddrx  <= '0;
    end else if (iowe) begin
      unique case (sel)
        SEL_PORT: portx <= wd;
        SEL_PIN:  portx <= portx ^ wd;
        SEL_DDR:  ddrx  <= wd;
        default:  ;
      endcase
    end
  end

`ifdef AVR_GPIO_PCINT_EN
  logic [P_WIDTH-1:0] pcmsk;
  logic [P_WIDTH-1:0] s3;
  logic               pcif_q;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      pcmsk  <= '0;
      s3     <= '0;
      pcif_q <= 1'b0;
    end else begin
      s3 <= s2;
      if (iowe && sel == SEL_PCMSK) pcmsk <= wd;
      if (|((s2 ^ s3) & pcmsk))     pcif_q <= 1'b1;
      else if (pcif_clr)            pcif_q <= 1'b0;
    end
  end

  assign pcif     = pcif_q;
  assign pcmsk_rd = pcmsk;
`else
  logic unused_cfg;
  assign unused_cfg = pcif_clr ^ (IO_Addr == PCMSK_ADDR);
  assign pcif       = 1'b0;
  assign pcmsk_rd   = '0;
`endif

  assign pcint_req = pcif & pcie;

  always_comb begin
    rd = '0;
    unique case (sel)
      SEL_PIN:   rd[P_WIDTH-1:0] = s2;
      SEL_DDR:   rd[P_WIDTH-1:0] = ddrx;
      SEL_PORT:  rd[P_WIDTH-1:0] = portx;
      SEL_PCMSK: rd[P_WIDTH-1:0] = pcmsk_rd;
      default:   rd = '0;
    endcase
  end

  assign out_en   = iore & (sel != SEL_NONE);
  assign dbus_out = out_en ? rd : 8'h00;

endmodule
